// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types for the oversampling UART receiver.
//   parity_mode_t : encoding of the parity_mode input (11 behaves as none)
//   rx_state_t    : receiver frame state machine states
//   parity_enabled: true when a parity bit follows the data bits
// ---------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      PARITY_NONE = 2'b00,
      PARITY_EVEN = 2'b01,
      PARITY_ODD  = 2'b10,
      PARITY_RSVD = 2'b11
   } parity_mode_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_t;

   // The reserved encoding is deliberately lumped in with "no parity".
   function automatic logic parity_enabled(input parity_mode_t mode);
      return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
   endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// ---------------------------------------------------------------------------
// uart_rx_os_if
// Read side of the receiver FIFO: a valid/ready stream of received frames.
//   rd_valid : FIFO holds at least one frame
//   rd_ready : consumer accepts the head frame this cycle
//   rd_data  : head frame data bits, first received bit in the LSB
//   rd_perr  : head frame parity error flag
//   rd_ferr  : head frame framing error flag
// master = receiver side, slave = consumer side.
// ---------------------------------------------------------------------------
interface uart_rx_os_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  rd_valid;
   logic                  rd_ready;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_perr;
   logic                  rd_ferr;

   modport master (
      output rd_valid,
      output rd_data,
      output rd_perr,
      output rd_ferr,
      input  rd_ready
   );

   modport slave (
      input  rd_valid,
      input  rd_data,
      input  rd_perr,
      input  rd_ferr,
      output rd_ready
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Small synchronous FIFO holding completed receive frames.
//   clk, reset : clock, asynchronous active-low reset
//   push/wdata : write request and frame to store
//   pop        : read request; rdata always shows the head entry
//   full/empty : occupancy flags
// A push while full is accepted only when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];

   // Storage, pointers and occupancy. DEPTH is a power of two, so the
   // pointers wrap simply by overflowing. The storage is cleared on reset
   // so the read port shows zero until the first frame arrives.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end
endmodule

// File: rtl/uart_rx_os.sv
// ---------------------------------------------------------------------------
// uart_rx_os
// Oversampling UART receiver with a receive FIFO.
//   clk, reset  : clock, asynchronous active-low reset
//   rx          : asynchronous serial line, idle high
//   baud_tick   : one-cycle strobe, OVERSAMPLE of them per bit period
//   parity_mode : 00 none, 01 even, 10 odd, 11 none (captured per frame)
//   stop_bits   : 0 one stop bit, 1 two stop bits (captured per frame)
//   overrun     : one-cycle pulse when a completed frame is dropped
//   busy        : receiver is inside a frame
//   rd_if       : valid/ready read port of the FIFO
// ---------------------------------------------------------------------------
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx,
   input  logic        baud_tick,
   input  logic [1:0]  parity_mode,
   input  logic        stop_bits,
   output logic        overrun,
   output logic        busy,
   uart_rx_os_if.master rd_if
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_WIDTH);
   localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);

   rx_state_t             state;
   rx_state_t             state_next;
   logic                  rx_meta;
   logic                  rx_sync;
   logic [1:0]            sync_fill;
   logic                  seen_high;
   logic [TW-1:0]         tick_cnt;
   logic [BW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic                  perr_r;
   logic                  ferr_acc;
   logic                  stop_cnt;
   parity_mode_t          mode_r;
   logic                  two_stop_r;
   logic                  start_edge;
   logic                  half_hit;
   logic                  bit_hit;
   logic                  push;
   logic [DATA_WIDTH+1:0] fifo_wdata;
   logic [DATA_WIDTH+1:0] fifo_rdata;
   logic                  fifo_full;
   logic                  fifo_empty;

   // half_hit marks the middle of the start bit, bit_hit the middle of every
   // later bit; both only fire on a baud_tick cycle.
   assign half_hit   = baud_tick && (state == ST_START) && (tick_cnt == HALF_LAST);
   assign bit_hit    = baud_tick && (state inside {ST_DATA, ST_PARITY, ST_STOP})
                       && (tick_cnt == BIT_LAST);
   assign busy       = (state != ST_IDLE);
   assign fifo_wdata = {ferr_acc | ~rx_sync, perr_r, shift_reg};

   // Two-flop synchronizer for the serial line. sync_fill tells us when the
   // synchronizer holds a real line sample rather than its reset value, and
   // seen_high arms start detection only after the line has been observed
   // high while idle. This keeps a line that is still low after reset or
   // after a broken frame from being mistaken for a new start bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta   <= 1'b1;
         rx_sync   <= 1'b1;
         sync_fill <= 2'b00;
         seen_high <= 1'b0;
      end else begin
         rx_meta   <= rx;
         rx_sync   <= rx_meta;
         sync_fill <= {sync_fill[0], 1'b1};
         if ((state != ST_IDLE) || start_edge) begin
            seen_high <= 1'b0;
         end else if (sync_fill[1] && rx_sync) begin
            seen_high <= 1'b1;
         end
      end
   end

   // Frame state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. The push to the FIFO happens on the last stop sample,
   // in the same cycle the machine heads back to IDLE.
   always_comb begin
      state_next = state;
      start_edge = 1'b0;
      push       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (seen_high && !rx_sync) begin
               start_edge = 1'b1;
               state_next = ST_START;
            end
         end
         ST_START: begin
            if (half_hit) begin
               state_next = rx_sync ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_hit && (bit_cnt == LAST_BIT)) begin
               state_next = parity_enabled(mode_r) ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (bit_hit) begin
               state_next = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_hit && (!two_stop_r || stop_cnt)) begin
               push       = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Frame datapath. Format settings are captured at the start edge so a
   // change in the middle of a frame only affects the next one. The tick
   // counter restarts at every sample point, so each sample lands mid-bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_cnt   <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         perr_r     <= 1'b0;
         ferr_acc   <= 1'b0;
         stop_cnt   <= 1'b0;
         mode_r     <= PARITY_NONE;
         two_stop_r <= 1'b0;
      end else begin
         if (start_edge) begin
            mode_r     <= parity_mode_t'(parity_mode);
            two_stop_r <= stop_bits;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            perr_r     <= 1'b0;
            ferr_acc   <= 1'b0;
         end
         if ((state == ST_IDLE) || half_hit || bit_hit) begin
            tick_cnt <= '0;
         end else if (baud_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
         end
         if (bit_hit) begin
            case (state)
               ST_DATA: begin
                  shift_reg <= {rx_sync, shift_reg[DATA_WIDTH-1:1]};
                  bit_cnt   <= bit_cnt + 1'b1;
               end
               ST_PARITY: begin
                  perr_r <= (^shift_reg) ^ rx_sync ^ (mode_r == PARITY_ODD);
               end
               ST_STOP: begin
                  ferr_acc <= ferr_acc | ~rx_sync;
                  stop_cnt <= 1'b1;
               end
               default: begin
               end
            endcase
         end
      end
   end

   // A frame is dropped only when the FIFO is full and the consumer is not
   // taking the head entry in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overrun <= 1'b0;
      end else begin
         overrun <= push && fifo_full && !rd_if.rd_ready;
      end
   end

   uart_rx_fifo #(
      .WIDTH (DATA_WIDTH + 2),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (fifo_wdata),
      .pop   (rd_if.rd_ready),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign rd_if.rd_valid = ~fifo_empty;
   assign {rd_if.rd_ferr, rd_if.rd_perr, rd_if.rd_data} = fifo_rdata;
endmodule

// File: tb/tb_uart_rx_os.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_os
// Directed self-checking bench for uart_rx_os (8 data bits, 16x oversample,
// 4-entry FIFO). baud_tick fires every 4 clocks, so one bit is 64 clocks.
// ---------------------------------------------------------------------------
module tb_uart_rx_os;
   import uart_pkg::*;

   localparam int BIT_CLKS   = 64;
   localparam int PUSH_TICKS = 8 + 8 * 16 + 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rx = 1'b1;
   logic       baud_tick = 1'b0;
   logic [1:0] parity_mode = 2'b00;
   logic       stop_bits = 1'b0;
   logic       overrun;
   logic       busy;

   int         n_compared = 0;
   int         n_mismatched = 0;
   int         ovr_count = 0;
   int         tick_div = 0;
   logic [9:0] got_q [$];
   logic [7:0] part_byte;
   logic       found;

   uart_rx_os_if #(.DATA_WIDTH(8)) rd_bus ();

   uart_rx_os #(
      .DATA_WIDTH (8),
      .OVERSAMPLE (16),
      .FIFO_DEPTH (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx          (rx),
      .baud_tick   (baud_tick),
      .parity_mode (parity_mode),
      .stop_bits   (stop_bits),
      .overrun     (overrun),
      .busy        (busy),
      .rd_if       (rd_bus)
   );

   // Free-running clock.
   initial begin
      forever #5 clk = ~clk;
   end

   // baud_tick: high for one clock out of every four, changed on negedge.
   initial begin
      forever begin
         @(negedge clk);
         tick_div  = (tick_div + 1) % 4;
         baud_tick = (tick_div == 0);
      end
   end

   // Record every accepted read and every overrun pulse, late in the cycle.
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (rd_bus.rd_valid && rd_bus.rd_ready) begin
            got_q.push_back({rd_bus.rd_ferr, rd_bus.rd_perr, rd_bus.rd_data});
         end
         if (overrun) begin
            ovr_count++;
         end
      end
   end

   // Hard stop if something hangs.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic expectEntry(input string tag, input logic [9:0] exp);
      logic [31:0] obs;
      obs = 32'hFFFF_FFFF;
      if (got_q.size() > 0) begin
         obs = 32'(got_q.pop_front());
      end
      checkOutput(tag, obs, 32'(exp));
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sendBit(input logic b);
      rx = b;
      idle(BIT_CLKS);
   endtask

   // One frame: start, 8 data bits LSB first, optional parity, one or two
   // stop bits, then one bit time of idle line.
   task automatic applyStimulus(input logic [7:0] d, input bit has_par, input bit par_bit,
                                input bit two_stop, input bit stop1, input bit stop2);
      sendBit(1'b0);
      for (int i = 0; i < 8; i++) begin
         sendBit(d[i]);
      end
      if (has_par) begin
         sendBit(par_bit);
      end
      sendBit(stop1);
      if (two_stop) begin
         sendBit(stop2);
      end
      sendBit(1'b1);
   endtask

   task automatic drain();
      rd_bus.rd_ready = 1'b1;
      idle(10);
      rd_bus.rd_ready = 1'b0;
   endtask

   // Raise rd_ready for exactly the cycle of the final stop sample of an
   // 8N1 frame: that is the PUSH_TICKS-th baud_tick seen while busy.
   task automatic coincidePop(output logic ok);
      int cnt;
      ok  = 1'b0;
      cnt = 0;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         #1;
         if (!busy) begin
            cnt = 0;
         end else if (baud_tick) begin
            cnt++;
         end
         if (cnt == PUSH_TICKS) begin
            rd_bus.rd_ready = 1'b1;
            @(negedge clk);
            rd_bus.rd_ready = 1'b0;
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      rd_bus.rd_ready = 1'b0;
      part_byte = 8'h33;
      found = 1'b0;

      // Reset state.
      idle(5);
      checkOutput("reset_rd_valid", 32'(rd_bus.rd_valid), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_overrun", 32'(overrun), 32'd0);
      checkOutput("reset_rd_data", 32'(rd_bus.rd_data), 32'd0);
      checkOutput("reset_perr_ferr", 32'({rd_bus.rd_ferr, rd_bus.rd_perr}), 32'd0);
      reset = 1'b1;
      idle(2 * BIT_CLKS);

      // 8N1 0xA5.
      rd_bus.rd_ready = 1'b1;
      applyStimulus(8'hA5, 0, 0, 0, 1, 1);
      checkOutput("8n1_count", 32'(got_q.size()), 32'd1);
      expectEntry("8n1_entry", {2'b00, 8'hA5});
      checkOutput("8n1_busy", 32'(busy), 32'd0);

      // 8E1 0x03 with parity bit 1: even parity violated.
      parity_mode = 2'b01;
      applyStimulus(8'h03, 1, 1, 0, 1, 1);
      expectEntry("8e1_perr", {2'b01, 8'h03});

      // 8O1 0x03 with parity bit 1: correct; mode switched to even mid-frame.
      parity_mode = 2'b10;
      fork
         applyStimulus(8'h03, 1, 1, 0, 1, 1);
         begin
            idle(3 * BIT_CLKS);
            parity_mode = 2'b01;
         end
      join
      expectEntry("8o1_ok", {2'b00, 8'h03});
      parity_mode = 2'b00;

      // 8N2 0x7E with second stop bit 0.
      stop_bits = 1'b1;
      applyStimulus(8'h7E, 0, 0, 1, 1, 0);
      expectEntry("8n2_ferr", {2'b10, 8'h7E});
      stop_bits = 1'b0;

      // Break: all-zero frame, then line returns high.
      applyStimulus(8'h00, 0, 0, 0, 0, 0);
      expectEntry("break_ferr", {2'b10, 8'h00});
      idle(2 * BIT_CLKS);
      checkOutput("break_no_restart", 32'(busy), 32'd0);
      checkOutput("break_no_extra", 32'(got_q.size()), 32'd0);

      // False start: 3-tick low pulse.
      rx = 1'b0;
      idle(8);
      checkOutput("fs_busy_high", 32'(busy), 32'd1);
      idle(4);
      rx = 1'b1;
      idle(BIT_CLKS);
      checkOutput("fs_busy_low", 32'(busy), 32'd0);
      checkOutput("fs_no_push", 32'(got_q.size()), 32'd0);
      checkOutput("fs_no_valid", 32'(rd_bus.rd_valid), 32'd0);

      // Overrun: five frames into a 4-entry FIFO with no reads.
      rd_bus.rd_ready = 1'b0;
      ovr_count = 0;
      for (int v = 1; v <= 5; v++) begin
         applyStimulus(8'(v), 0, 0, 0, 1, 1);
      end
      checkOutput("ovr_pulses", 32'(ovr_count), 32'd1);
      checkOutput("ovr_valid", 32'(rd_bus.rd_valid), 32'd1);
      checkOutput("ovr_head_stable", 32'(rd_bus.rd_data), 32'h01);
      drain();
      checkOutput("ovr_read_count", 32'(got_q.size()), 32'd4);
      for (int v = 1; v <= 4; v++) begin
         expectEntry("ovr_entry", {2'b00, 8'(v)});
      end
      checkOutput("ovr_empty", 32'(rd_bus.rd_valid), 32'd0);

      // Full FIFO with a pop in the same cycle as the fifth push.
      ovr_count = 0;
      for (int v = 1; v <= 4; v++) begin
         applyStimulus(8'(v), 0, 0, 0, 1, 1);
      end
      fork
         applyStimulus(8'h05, 0, 0, 0, 1, 1);
         coincidePop(found);
      join
      checkOutput("coin_found", 32'(found), 32'd1);
      checkOutput("coin_no_overrun", 32'(ovr_count), 32'd0);
      checkOutput("coin_one_pop", 32'(got_q.size()), 32'd1);
      expectEntry("coin_popped", {2'b00, 8'h01});
      drain();
      checkOutput("coin_read_count", 32'(got_q.size()), 32'd4);
      for (int v = 2; v <= 5; v++) begin
         expectEntry("coin_entry", {2'b00, 8'(v)});
      end

      // Reset in the middle of data bit 4 with an entry already stored.
      applyStimulus(8'h11, 0, 0, 0, 1, 1);
      checkOutput("pre_reset_valid", 32'(rd_bus.rd_valid), 32'd1);
      sendBit(1'b0);
      for (int i = 0; i < 4; i++) begin
         sendBit(part_byte[i]);
      end
      rx = part_byte[4];
      idle(BIT_CLKS / 2);
      checkOutput("mid_frame_busy", 32'(busy), 32'd1);
      reset = 1'b0;
      rx = 1'b1;
      idle(2);
      checkOutput("rst_rd_valid", 32'(rd_bus.rd_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_rd_data", 32'(rd_bus.rd_data), 32'd0);
      checkOutput("rst_flags", 32'({rd_bus.rd_ferr, rd_bus.rd_perr, overrun}), 32'd0);
      reset = 1'b1;
      idle(2 * BIT_CLKS);
      checkOutput("post_rst_idle", 32'(busy), 32'd0);
      checkOutput("post_rst_empty", 32'(rd_bus.rd_valid), 32'd0);
      rd_bus.rd_ready = 1'b1;
      applyStimulus(8'h5A, 0, 0, 0, 1, 1);
      checkOutput("post_rst_count", 32'(got_q.size()), 32'd1);
      expectEntry("post_rst_5a", {2'b00, 8'h5A});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end
endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter OVERSAMPLE, default 16: baud_tick pulses per bit period, even, at least 4.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: receive FIFO entries, power of two, at least 2.
REQ-004 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port rx, input, 1: serial line, asynchronous to clk, idle high.
REQ-007 SHALL have port baud_tick, input, 1: one-cycle sample-rate strobe.
REQ-008 SHALL have port parity_mode, input, 2: 00 none, 01 even, 10 odd, 11 treated as none.
REQ-009 SHALL have port stop_bits, input, 1: 0 selects one stop bit, 1 selects two.
REQ-010 SHALL have port rd_ready, input, 1: consumer accepts the head FIFO entry.
REQ-011 SHALL have port rd_valid, output, 1: FIFO non-empty.
REQ-012 SHALL have port rd_data, output, DATA_WIDTH: head-entry data, LSB received first.
REQ-013 SHALL have port rd_perr, output, 1: head-entry parity error.
REQ-014 SHALL have port rd_ferr, output, 1: head-entry framing error.
REQ-015 SHALL have port overrun, output, 1: one-cycle pulse when a completed frame is dropped.
REQ-016 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-017 SHALL pass rx through a two-flop synchronizer; all decisions use the synchronized value.
REQ-018 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE -> START on a synchronized high-to-low transition; latch parity_mode and stop_bits at that edge; clear the tick counter.
REQ-020 START: at OVERSAMPLE/2 ticks, rx=0 -> DATA; rx=1 -> IDLE (false start, nothing pushed).
REQ-021 DATA/PARITY/STOP: sample once every OVERSAMPLE ticks, mid-bit; ticks count only on cycles with baud_tick=1.
REQ-022 DATA: shift DATA_WIDTH bits LSB-first, then go to PARITY if latched mode is even/odd, else to STOP.
REQ-023 Parity error: even mode when the XOR of data bits and the parity bit is 1; odd mode when it is 0.
REQ-024 STOP: sample one or two stop bits; any zero stop sample sets ferr; a break (all-zero frame) pushes with ferr=1.
REQ-025 On the final stop sample, push {ferr, perr, data} and return to IDLE in the same cycle; the next falling edge is detected only after rx has been seen high.
REQ-026 rd_valid SHALL rise the cycle after the push; latency is one clk from the final stop sample.
REQ-027 Pop SHALL occur when rd_valid and rd_ready are both high; rd_data, rd_perr and rd_ferr hold stable while rd_valid=1 and rd_ready=0.
REQ-028 FIFO full at push with no pop in that cycle: drop the new frame, keep the stored entries, pulse overrun.
REQ-029 FIFO full at push with a pop in the same cycle: accept the push, no overrun; occupancy is unchanged.
REQ-030 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter is $clog2(FIFO_DEPTH)+1 bits wide.
REQ-031 Changes to parity_mode or stop_bits mid-frame SHALL take effect only at the next start edge.

Reset
REQ-032 reset=0 SHALL force IDLE, synchronizer flops to 1, counters to 0, FIFO empty, and rd_valid, overrun, busy, rd_perr, rd_ferr and rd_data to 0.
REQ-033 Reset mid-frame SHALL discard the partial frame; after release, reception restarts only on a fresh falling edge.

Structure
REQ-034 Package uart_pkg SHALL hold the parity_mode_t enum, the rx_state_t enum and the PARITY_NONE/EVEN/ODD constants.
REQ-035 The FIFO SHALL be a sub-module uart_rx_fifo (parameters WIDTH, DEPTH) with push/pop/full/empty.

Verification
REQ-036 8N1, byte 0xA5, rd_ready=1 -> one entry 0xA5, perr=0, ferr=0.
REQ-037 8E1, byte 0x03, parity bit 1 -> entry 0x03, perr=1; repeat with 8O1 and parity bit 1 -> perr=0.
REQ-038 8N2, byte 0x7E, second stop bit 0 -> entry 0x7E, ferr=1.
REQ-039 rx low pulse of 3 ticks at OVERSAMPLE=16 -> returns to IDLE, no push, busy drops.
REQ-040 FIFO_DEPTH=4, rd_ready=0, five frames 0x01..0x05 -> overrun pulses once, entries read back 0x01..0x04; repeat with a pop coinciding with the fifth push -> no overrun.
REQ-041 reset asserted during bit 4 of a frame -> outputs zero, FIFO empty; next full frame 0x5A received correctly.
